// File: rtl/shift_arbiter.sv
// Round-robin front end that shares one combinational 16-bit shifter among NREQ requesters.
// Each accepted request takes three cycles: IDLE (grant/capture) -> EXEC (shift) -> RESP (hold until accepted).
module shift_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [16*NREQ-1:0]  req_a,
  input  logic [4*NREQ-1:0]   req_d,
  input  logic [2*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]     req_ready,
  output logic [15:0]         sh_a,
  output logic [3:0]          sh_d,
  output logic [1:0]          sh_op,
  input  logic [15:0]         sh_res,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         rsp_res,
  input  logic                rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [15:0]     op_a_reg;
  logic [3:0]      op_d_reg;
  logic [1:0]      op_op_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [15:0]     rsp_res_reg;

  logic [15:0]     a_arr  [NREQ];
  logic [3:0]      d_arr  [NREQ];
  logic [1:0]      op_arr [NREQ];
  logic [NREQ-1:0] at_or_after;
  logic [NREQ-1:0] hi_valid;
  logic [NREQ-1:0] pick_vec;
  logic [IDW-1:0]  grant_idx;
  logic            grant_found;
  logic            do_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi]       = req_a[16*gi +: 16];
      assign d_arr[gi]       = req_d[4*gi +: 4];
      assign op_arr[gi]      = req_op[2*gi +: 2];
      assign at_or_after[gi] = (IDW'(gi) >= rr_ptr_reg);
    end
  endgenerate

  // Cyclic search: prefer valid requesters at or above rr_ptr, else wrap to the lowest valid one.
  assign hi_valid    = req_valid & at_or_after;
  assign pick_vec    = (|hi_valid) ? hi_valid : req_valid;
  assign grant_found = |req_valid;

  always_comb begin
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        grant_idx = IDW'(i);
      end
    end
  end

  assign do_grant = (state_reg == IDLE) && grant_found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && do_grant) begin
      req_ready[grant_idx] = 1'b1;
    end
    rsp_valid = rst_n && (state_reg == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      op_a_reg    <= '0;
      op_d_reg    <= '0;
      op_op_reg   <= '0;
      rsp_id_reg  <= '0;
      rsp_res_reg <= '0;
    end else begin
      if (do_grant) begin
        op_a_reg   <= a_arr[grant_idx];
        op_d_reg   <= d_arr[grant_idx];
        op_op_reg  <= op_arr[grant_idx];
        rsp_id_reg <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (state_reg == EXEC) begin
        rsp_res_reg <= sh_res;
      end
    end
  end

  // The shifter inputs follow the operand regs at all times; only EXEC samples its result.
  assign sh_a    = op_a_reg;
  assign sh_d    = op_d_reg;
  assign sh_op   = op_op_reg;
  assign rsp_id  = rsp_id_reg;
  assign rsp_res = rsp_res_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (NREQ=2) with a behavioural 16-bit shifter on the sh_* port.
module tb_shift_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_d;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       sh_a;
  logic [3:0]        sh_d;
  logic [1:0]        sh_op;
  logic [15:0]       sh_res;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_res;
  logic              rsp_ready;

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_d     (req_d),
    .req_op    (req_op),
    .req_ready (req_ready),
    .sh_a      (sh_a),
    .sh_d      (sh_d),
    .sh_op     (sh_op),
    .sh_res    (sh_res),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared shifter: 00 SLL, 01 rotate left, 10 SRL, 11 rotate right.
  always_comb begin
    logic [31:0] tmp;
    tmp = {sh_a, sh_a};
    sh_res = 16'h0000;
    case (sh_op)
      2'b00: sh_res = sh_a << sh_d;
      2'b01: begin tmp = tmp << sh_d; sh_res = tmp[31:16]; end
      2'b10: sh_res = sh_a >> sh_d;
      default: begin tmp = tmp >> sh_d; sh_res = tmp[15:0]; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [3:0] d,
                         input logic [1:0] op, input logic v);
    req_a[16*i +: 16] = a;
    req_d[4*i +: 4]   = d;
    req_op[2*i +: 2]  = op;
    req_valid[i]      = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 16'hFFFF, 4'hF, 2'b11, 1'b1);
    set_req(1, 16'hAAAA, 4'h5, 2'b01, 1'b1);
    tick();
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if ({sh_a, sh_d, sh_op} !== 22'd0) begin errors++; $display("FAIL reset_sh got=%h/%h/%b want=0", sh_a, sh_d, sh_op); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_release_grant got=%b want=01", req_ready); end
    $display("reset: req_ready=%b rsp_valid=%b after release", req_ready, rsp_valid);
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_op();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'h8001, 4'd1, 2'b01, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec got=ready %b valid %b want=00 0", req_ready, rsp_valid); end
    checks++; if ({sh_a, sh_d, sh_op} !== {16'h8001, 4'd1, 2'b01}) begin errors++; $display("FAIL single_sh got=%h/%h/%b want=8001/1/01", sh_a, sh_d, sh_op); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 16'h0003) begin errors++; $display("FAIL single_rsp1 got=%b/%0d/%h want=1/0/0003", rsp_valid, rsp_id, rsp_res); end
    $display("single op1: id=%0d res=%h", rsp_id, rsp_res);
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_accept got=%b want=0", rsp_valid); end
    set_req(0, 16'hF000, 4'd4, 2'b10, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_wrap_grant got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 16'h0F00) begin errors++; $display("FAIL single_rsp2 got=%b/%0d/%h want=1/0/0f00", rsp_valid, rsp_id, rsp_res); end
    $display("single op2: id=%0d res=%h", rsp_id, rsp_res);
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_res;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'h00F0, 4'd2, 2'b00, 1'b1);
    set_req(1, 16'h0F00, 4'd4, 2'b10, 1'b1);
    for (int n = 0; n < 4; n++) begin
      exp_res = (n % 2 == 1) ? 16'h00F0 : 16'h03C0;
      #1;
      checks++; if (req_ready !== ((n % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got=%b want=%0d", n, req_ready, n % 2); end
      tick();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_exec_ready%0d got=%b want=00", n, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(n % 2) || rsp_res !== exp_res) begin errors++; $display("FAIL rr_rsp%0d got=%b/%0d/%h want=1/%0d/%h", n, rsp_valid, rsp_id, rsp_res, n % 2, exp_res); end
      $display("round robin %0d: id=%0d res=%h", n, rsp_id, rsp_res);
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 16'h1234, 4'd4, 2'b01, 1'b1);
    set_req(1, 16'h8000, 4'd15, 2'b11, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0 got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 16'h2341 || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%0d/%h ready=%b want=1/0/2341 ready=00", n, rsp_valid, rsp_id, rsp_res, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_accept got=valid %b ready %b want=1 00", rsp_valid, req_ready); end
    $display("backpressure: accepted id=%0d res=%h", rsp_id, rsp_res);
    tick();
    checks++; if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next_grant got=%b valid %b want=10 0", req_ready, rsp_valid); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 16'h0001) begin errors++; $display("FAIL bp_rsp1 got=%b/%0d/%h want=1/1/0001", rsp_valid, rsp_id, rsp_res); end
    $display("backpressure: next id=%0d res=%h", rsp_id, rsp_res);
    tick();
  endtask

  task automatic test_boundary();
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 16'h1234, 4'd0, 2'b11, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bnd_grant1 got=%b want=10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 16'h1234) begin errors++; $display("FAIL bnd_rotr0 got=%b/%0d/%h want=1/1/1234", rsp_valid, rsp_id, rsp_res); end
    $display("boundary rotr d=0: res=%h", rsp_res);
    tick();
    set_req(0, 16'h0003, 4'd15, 2'b00, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bnd_grant0 got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 16'h8000) begin errors++; $display("FAIL bnd_sll15 got=%b/%0d/%h want=1/0/8000", rsp_valid, rsp_id, rsp_res); end
    $display("boundary sll d=15: res=%h", rsp_res);
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'hAAAA, 4'd3, 2'b00, 1'b1);
    #1;
    tick();
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || sh_a !== 16'h0000) begin errors++; $display("FAIL midrst_state got=%b/%b/%h want=0/00/0000", rsp_valid, req_ready, sh_a); end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp%0d got=%b want=0", n, rsp_valid); end
    end
    set_req(1, 16'h00FF, 4'd8, 2'b00, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL midrst_grant got=%b want=10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 16'hFF00) begin errors++; $display("FAIL midrst_rsp got=%b/%0d/%h want=1/1/ff00", rsp_valid, rsp_id, rsp_res); end
    $display("reset mid-op: recovered id=%0d res=%h", rsp_id, rsp_res);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_d = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
